// File: rtl/counter_seq_pkg.sv
// -----------------------------------------------------------------------------
// counter_seq_pkg
// Shared definitions for the counter sequencing controller: state encoding,
// default data/hold widths and the RUN watchdog limit.
// -----------------------------------------------------------------------------
package counter_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_SHOW = 2'd3
    } state_t;

    localparam int WIDTH_DEF  = 8;
    localparam int HOLD_W_DEF = 4;

    // Watchdog counts unpaused RUN cycles; a run that has not matched after
    // this many of them is declared stuck.
    localparam int              WD_W     = 9;
    localparam logic [WD_W-1:0] WD_LIMIT = 9'd256;

endpackage

// File: rtl/counter_seq_ctrl.sv
// -----------------------------------------------------------------------------
// counter_seq_ctrl
// Sequences an external load/enable counter through one run:
// IDLE -> LOAD (load start value) -> RUN (count up to end value, wrap legal)
// -> SHOW (output enable for hold_cycles+1 cycles, done on the last) -> IDLE.
// A watchdog aborts RUN with a sticky err if the counter never reaches the
// end value within 256 unpaused cycles.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             request a run (accepted only in IDLE with abort low)
//   abort             return to IDLE from any busy state, no done
//   pause             freeze counting during RUN
//   start_val/end_val counter start and terminal values (captured on start)
//   hold_cycles       SHOW length minus one (captured on start)
//   cnt_q             current value of the external counter
//   cnt_load          counter load strobe (LOAD only)
//   cnt_load_data     captured start value
//   cnt_en            counter increment enable (RUN, Mealy on cnt_q/pause)
//   cnt_oe            counter output enable (SHOW)
//   busy              high in every state except IDLE
//   done              one-cycle completion pulse
//   err               sticky watchdog error
//   state             current state encoding
// -----------------------------------------------------------------------------
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int HOLD_W = HOLD_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              pause,
    input  logic [WIDTH-1:0]  start_val,
    input  logic [WIDTH-1:0]  end_val,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic [WIDTH-1:0]  cnt_q,
    output logic              cnt_load,
    output logic [WIDTH-1:0]  cnt_load_data,
    output logic              cnt_en,
    output logic              cnt_oe,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        state
);

    state_t            r_state;
    state_t            w_next_state;
    logic [WIDTH-1:0]  r_start_reg;
    logic [WIDTH-1:0]  r_end_reg;
    logic [HOLD_W-1:0] r_hold_reg;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [WD_W-1:0]   r_wd_cnt;
    logic [WD_W-1:0]   w_wd_inc;
    logic              r_err;
    logic              w_capture;
    logic              w_wd_trip;
    logic              w_match;
    logic              w_hold_last;

    assign w_match     = (cnt_q == r_end_reg);
    assign w_hold_last = (r_hold_cnt == r_hold_reg);
    assign w_wd_inc    = r_wd_cnt + 9'd1;

    // Next-state selection; abort overrides every other transition.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_wd_trip    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_LOAD;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_match) begin
                    w_next_state = ST_SHOW;
                end else if (!pause && (w_wd_inc == WD_LIMIT)) begin
                    // This is the 256th unpaused cycle without a match.
                    w_wd_trip    = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_SHOW: begin
                if (abort || w_hold_last) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_SHOW;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Counter strobes and completion pulse decoded from the current state.
    always_comb begin
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_oe   = 1'b0;
        done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cnt_load = 1'b0;
            end
            ST_LOAD: begin
                cnt_load = 1'b1;
            end
            ST_RUN: begin
                // Mealy: stop incrementing on the very cycle cnt_q hits the end.
                cnt_en = ~w_match & ~pause;
            end
            ST_SHOW: begin
                cnt_oe = 1'b1;
                done   = w_hold_last & ~abort;
            end
            default: begin
                cnt_load = 1'b0;
            end
        endcase
    end

    assign cnt_load_data = r_start_reg;
    assign busy          = (r_state != ST_IDLE);
    assign err           = r_err;
    assign state         = r_state;

    // State, captured run parameters, hold/watchdog counts and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_start_reg <= '0;
            r_end_reg   <= '0;
            r_hold_reg  <= '0;
            r_hold_cnt  <= '0;
            r_wd_cnt    <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_capture) begin
                r_start_reg <= start_val;
                r_end_reg   <= end_val;
                r_hold_reg  <= hold_cycles;
            end else begin
                r_start_reg <= r_start_reg;
                r_end_reg   <= r_end_reg;
                r_hold_reg  <= r_hold_reg;
            end

            if (w_capture) begin
                r_err <= 1'b0;
            end else if (w_wd_trip) begin
                r_err <= 1'b1;
            end else begin
                r_err <= r_err;
            end

            // Held at zero outside RUN so every RUN entry starts from zero.
            if (r_state != ST_RUN) begin
                r_wd_cnt <= '0;
            end else if (!pause && !w_match) begin
                r_wd_cnt <= w_wd_inc;
            end else begin
                r_wd_cnt <= r_wd_cnt;
            end

            if (r_state != ST_SHOW) begin
                r_hold_cnt <= '0;
            end else if (!w_hold_last) begin
                r_hold_cnt <= r_hold_cnt + {{(HOLD_W-1){1'b0}}, 1'b1};
            end else begin
                r_hold_cnt <= r_hold_cnt;
            end
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_seq_ctrl
// Drives counter_seq_ctrl beside a behavioural counter8 model. Each scenario
// builds a per-cycle table of stimulus and expected outputs from run-level
// arithmetic (run length, pause window, hold length) and replays it.
// -----------------------------------------------------------------------------
module tb_counter_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, pause;
    logic [7:0] start_val, end_val;
    logic [3:0] hold_cycles;
    logic [7:0] cnt_q;
    logic       cnt_load, cnt_en, cnt_oe, busy, done, err;
    logic [7:0] cnt_load_data;
    logic [1:0] state;
    logic       stuck = 1'b0;

    int errors = 0;
    int checks = 0;
    int en_seen, run_seen, show_seen, done_seen;

    logic       model_err;
    logic [7:0] model_cap;

    typedef struct packed {
        logic       st;
        logic       ab;
        logic       pa;
        logic [7:0] sv;
        logic [7:0] ev;
        logic [3:0] hc;
        logic [1:0] e_state;
        logic       chk_q;
        logic [7:0] e_q;
        logic       e_en;
        logic       e_load;
        logic       e_oe;
        logic       e_done;
        logic       e_err;
        logic [7:0] e_ld;
    } ent_t;

    ent_t tr[$];

    counter_seq_ctrl #(.WIDTH(8), .HOLD_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
        .start_val(start_val), .end_val(end_val), .hold_cycles(hold_cycles),
        .cnt_q(cnt_q), .cnt_load(cnt_load), .cnt_load_data(cnt_load_data),
        .cnt_en(cnt_en), .cnt_oe(cnt_oe), .busy(busy), .done(done),
        .err(err), .state(state)
    );

    always #5 clk = ~clk;

    // Behavioural counter8: load beats enable; optional stuck mode never counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           cnt_q <= 8'h00;
        else if (stuck)    cnt_q <= 8'hA0;
        else if (cnt_load) cnt_q <= cnt_load_data;
        else if (cnt_en)   cnt_q <= cnt_q + 8'd1;
    end

    task automatic push(input logic st, input logic ab, input logic pa,
                        input logic [1:0] es, input logic cq, input logic [7:0] eq,
                        input logic en, input logic ld, input logic oe,
                        input logic dn, input logic er, input logic [7:0] eld,
                        input logic [7:0] sv, input logic [7:0] ev, input logic [3:0] hc);
        ent_t e;
        e.st = st; e.ab = ab; e.pa = pa; e.sv = sv; e.ev = ev; e.hc = hc;
        e.e_state = es; e.chk_q = cq; e.e_q = eq; e.e_en = en; e.e_load = ld;
        e.e_oe = oe; e.e_done = dn; e.e_err = er; e.e_ld = eld;
        tr.push_back(e);
    endtask

    task automatic push_idle(input logic st);
        push(st, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0,
             model_err, model_cap, 8'($urandom), 8'($urandom), 4'($urandom));
    endtask

    // One accepted run: IDLE(start) + LOAD + RUN + SHOW, no trailing IDLE.
    // Pause window covers RUN cycles [p, p+n); inputs other than start are
    // scrambled once busy since they are only captured in IDLE.
    task automatic add_run(input logic [7:0] sv, input logic [7:0] ev,
                           input logic [3:0] hc, input logic hs,
                           input int p, input int n);
        logic [7:0] d;
        logic [7:0] qv;
        int         len;
        int         i;
        logic       paused;
        d   = ev - sv;
        len = int'(d) + 1;
        push(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0,
             model_err, model_cap, sv, ev, hc);
        model_cap = sv;
        model_err = 1'b0;
        push(hs, 1'b0, 1'b0, 2'd1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0,
             1'b0, model_cap, 8'($urandom), 8'($urandom), 4'($urandom));
        qv = sv;
        i  = 0;
        for (int c = 0; c < 600; c++) begin
            paused = (c >= p) && (c < p + n);
            push(hs, 1'b0, paused, 2'd2, 1'b1, qv, !paused && (i != len - 1),
                 1'b0, 1'b0, 1'b0, 1'b0, model_cap,
                 8'($urandom), 8'($urandom), 4'($urandom));
            if (i == len - 1) break;
            if (!paused) begin
                i  = i + 1;
                qv = qv + 8'd1;
            end
        end
        for (int k = 0; k <= int'(hc); k++) begin
            push(hs, 1'b0, 1'b0, 2'd3, 1'b1, ev, 1'b0, 1'b0, 1'b1, (k == int'(hc)),
                 1'b0, model_cap, 8'($urandom), 8'($urandom), 4'($urandom));
        end
    endtask

    // Mark entry idx as the abort cycle and drop everything after it.
    task automatic cut_abort(input int idx);
        ent_t e;
        e        = tr[idx];
        e.ab     = 1'b1;
        e.e_done = 1'b0;
        tr[idx]  = e;
        while (tr.size() > idx + 1) void'(tr.pop_back());
    endtask

    // Replay the table: drive at edge+1, compare at edge+2.
    task automatic play_trace(input string name);
        ent_t e;
        int   cyc;
        cyc = 0;
        while (tr.size() > 0) begin
            e = tr.pop_front();
            start = e.st; abort = e.ab; pause = e.pa;
            start_val = e.sv; end_val = e.ev; hold_cycles = e.hc;
            #1;
            checks++; if (state !== e.e_state) begin errors++; $display("FAIL %s cyc%0d state got %0d exp %0d", name, cyc, state, e.e_state); end
            checks++; if (busy !== (e.e_state != 2'd0)) begin errors++; $display("FAIL %s cyc%0d busy got %b", name, cyc, busy); end
            checks++; if (cnt_load !== e.e_load) begin errors++; $display("FAIL %s cyc%0d cnt_load got %b exp %b", name, cyc, cnt_load, e.e_load); end
            checks++; if (cnt_load_data !== e.e_ld) begin errors++; $display("FAIL %s cyc%0d cnt_load_data got %h exp %h", name, cyc, cnt_load_data, e.e_ld); end
            checks++; if (cnt_en !== e.e_en) begin errors++; $display("FAIL %s cyc%0d cnt_en got %b exp %b", name, cyc, cnt_en, e.e_en); end
            checks++; if (cnt_oe !== e.e_oe) begin errors++; $display("FAIL %s cyc%0d cnt_oe got %b exp %b", name, cyc, cnt_oe, e.e_oe); end
            checks++; if (done !== e.e_done) begin errors++; $display("FAIL %s cyc%0d done got %b exp %b", name, cyc, done, e.e_done); end
            checks++; if (err !== e.e_err) begin errors++; $display("FAIL %s cyc%0d err got %b exp %b", name, cyc, err, e.e_err); end
            if (e.chk_q) begin
                checks++; if (cnt_q !== e.e_q) begin errors++; $display("FAIL %s cyc%0d cnt_q got %h exp %h", name, cyc, cnt_q, e.e_q); end
            end
            if (cnt_en === 1'b1)   en_seen++;
            if (state === 2'd2)    run_seen++;
            if (state === 2'd3)    show_seen++;
            if (done === 1'b1)     done_seen++;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; abort = 1'b0; pause = 1'b0;
    endtask

    task automatic clr_seen();
        en_seen = 0; run_seen = 0; show_seen = 0; done_seen = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
        start_val = 8'h00; end_val = 8'h00; hold_cycles = 4'h0;
        model_err = 1'b0; model_cap = 8'h00;
        #3;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset state got %0d exp 0", state); end
        checks++; if ({busy, done, err, cnt_load, cnt_en, cnt_oe} !== 6'b0) begin errors++; $display("FAIL reset strobes got %b exp 000000", {busy, done, err, cnt_load, cnt_en, cnt_oe}); end
        checks++; if (cnt_load_data !== 8'h00) begin errors++; $display("FAIL reset load_data got %h exp 00", cnt_load_data); end
        #4 rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset idle state got %0d exp 0", state); end
    endtask

    task automatic test_basic();
        clr_seen();
        add_run(8'h10, 8'h14, 4'd2, 1'b0, 0, 0);
        push_idle(1'b0);
        play_trace("basic");
        checks++; if (run_seen != 5)  begin errors++; $display("FAIL basic run_cycles got %0d exp 5", run_seen); end
        checks++; if (en_seen != 4)   begin errors++; $display("FAIL basic en_cycles got %0d exp 4", en_seen); end
        checks++; if (show_seen != 3) begin errors++; $display("FAIL basic show_cycles got %0d exp 3", show_seen); end
        checks++; if (done_seen != 1) begin errors++; $display("FAIL basic done_count got %0d exp 1", done_seen); end
    endtask

    task automatic test_wrap();
        clr_seen();
        add_run(8'hFE, 8'h01, 4'd0, 1'b0, 0, 0);
        push_idle(1'b0);
        play_trace("wrap");
        checks++; if (en_seen != 3)  begin errors++; $display("FAIL wrap en_cycles got %0d exp 3", en_seen); end
        checks++; if (run_seen != 4) begin errors++; $display("FAIL wrap run_cycles got %0d exp 4", run_seen); end
    endtask

    task automatic test_equal();
        clr_seen();
        add_run(8'h55, 8'h55, 4'd1, 1'b0, 0, 0);
        push_idle(1'b0);
        play_trace("equal");
        checks++; if (run_seen != 1)  begin errors++; $display("FAIL equal run_cycles got %0d exp 1", run_seen); end
        checks++; if (en_seen != 0)   begin errors++; $display("FAIL equal en_cycles got %0d exp 0", en_seen); end
        checks++; if (done_seen != 1) begin errors++; $display("FAIL equal done_count got %0d exp 1", done_seen); end
    endtask

    task automatic test_abort_pause();
        clr_seen();
        add_run(8'h10, 8'h14, 4'd2, 1'b0, 0, 0);
        cut_abort(4);               // IDLE, LOAD, RUN q=10, 11, 12 <- abort here
        push_idle(1'b0);
        push_idle(1'b0);
        play_trace("abort");
        checks++; if (done_seen != 0) begin errors++; $display("FAIL abort done_count got %0d exp 0", done_seen); end
        clr_seen();
        add_run(8'h10, 8'h14, 4'd0, 1'b0, 1, 3);
        push_idle(1'b0);
        play_trace("pause");
        checks++; if (run_seen != 8) begin errors++; $display("FAIL pause run_cycles got %0d exp 8", run_seen); end
        checks++; if (en_seen != 4)  begin errors++; $display("FAIL pause en_cycles got %0d exp 4", en_seen); end
    endtask

    task automatic test_watchdog();
        logic paused;
        clr_seen();
        stuck = 1'b1;
        push(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0,
             model_err, model_cap, 8'h00, 8'h05, 4'd1);
        model_cap = 8'h00;
        model_err = 1'b0;
        push(1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0,
             1'b0, model_cap, 8'h00, 8'h05, 4'd1);
        // 256 counted cycles plus 3 paused ones that the watchdog skips.
        for (int c = 0; c < 259; c++) begin
            paused = (c >= 10) && (c < 13);
            push(1'b0, 1'b0, paused, 2'd2, 1'b1, 8'hA0, !paused, 1'b0, 1'b0, 1'b0,
                 1'b0, model_cap, 8'($urandom), 8'($urandom), 4'($urandom));
        end
        model_err = 1'b1;
        for (int k = 0; k < 4; k++) push_idle(1'b0);
        play_trace("watchdog");
        stuck = 1'b0;
        checks++; if (done_seen != 0) begin errors++; $display("FAIL watchdog done_count got %0d exp 0", done_seen); end
        add_run(8'h20, 8'h22, 4'd0, 1'b0, 0, 0);
        push_idle(1'b0);
        play_trace("err_clear");
    endtask

    task automatic test_back_to_back();
        clr_seen();
        add_run(8'h40, 8'h43, 4'd1, 1'b1, 0, 0);
        add_run(8'h80, 8'h81, 4'd0, 1'b0, 0, 0);
        push_idle(1'b0);
        play_trace("back_to_back");
        checks++; if (done_seen != 2) begin errors++; $display("FAIL back_to_back done_count got %0d exp 2", done_seen); end
    endtask

    task automatic test_random();
        logic [7:0] sv;
        logic [7:0] ev;
        logic [7:0] d;
        int         len, p, n, sz;
        for (int r = 0; r < 10; r++) begin
            sv  = 8'($urandom);
            ev  = sv + 8'($urandom_range(0, 12));
            d   = ev - sv;
            len = int'(d) + 1;
            p   = 0;
            n   = 0;
            if (len >= 2) begin
                p = $urandom_range(0, len - 2);
                n = $urandom_range(0, 3);
            end
            add_run(sv, ev, 4'($urandom_range(0, 3)), 1'b0, p, n);
            sz = tr.size();
            if ($urandom_range(0, 3) == 0) cut_abort($urandom_range(1, sz - 1));
            push_idle(1'b0);
            play_trace("random");
        end
    endtask

    task automatic test_rst_show();
        clr_seen();
        add_run(8'h30, 8'h31, 4'd5, 1'b0, 0, 0);
        while (tr.size() > 6) void'(tr.pop_back());   // stop after SHOW cycle 2
        play_trace("rst_show_pre");
        #2;
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL rst_show pre state got %0d exp 3", state); end
        rst = 1'b1;
        #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_show state got %0d exp 0", state); end
        checks++; if (cnt_oe !== 1'b0) begin errors++; $display("FAIL rst_show cnt_oe got %b exp 0", cnt_oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_show busy got %b exp 0", busy); end
        checks++; if ({done, err, cnt_load, cnt_en} !== 4'b0) begin errors++; $display("FAIL rst_show strobes got %b exp 0000", {done, err, cnt_load, cnt_en}); end
        checks++; if (cnt_load_data !== 8'h00) begin errors++; $display("FAIL rst_show load_data got %h exp 00", cnt_load_data); end
        #1 rst = 1'b0;
        model_cap = 8'h00;
        model_err = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) push_idle(1'b0);
        play_trace("rst_show_post");
        checks++; if (done_seen != 0) begin errors++; $display("FAIL rst_show done_count got %0d exp 0", done_seen); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_equal();
        test_abort_pause();
        test_watchdog();
        test_back_to_back();
        test_random();
        test_rst_show();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
